// File: rtl/buffer_load_ctrl.sv
// Sequencing controller for the pixel input buffer: gates the pixel stream into the buffer,
// kicks off the compute stage once the buffer is full, then clears the buffer and re-arms.
module buffer_load_ctrl #(
   parameter int DATA_WIDTH      = 8,
   parameter int DEPTH           = 4,
   parameter int CNT_WIDTH       = $clog2(DEPTH) + 1,
   parameter int LOADED_TIMEOUT  = 4,
   parameter int FRAME_CNT_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       auto_rearm,
   input  logic                       abort,
   input  logic                       s_valid,
   input  logic [DATA_WIDTH-1:0]      s_data,
   output logic                       s_ready,
   output logic                       buf_load_en,
   output logic [DATA_WIDTH-1:0]      buf_data,
   output logic                       buf_clear,
   input  logic                       buf_ready,
   input  logic                       buf_loaded,
   output logic                       comp_start,
   input  logic                       comp_done,
   output logic                       busy,
   output logic [FRAME_CNT_WIDTH-1:0] frame_cnt,
   output logic                       err_timeout
);

   localparam int TMO_WIDTH = $clog2(LOADED_TIMEOUT) + 1;
   localparam logic [CNT_WIDTH-1:0] PIX_FULL = CNT_WIDTH'(DEPTH);
   localparam logic [CNT_WIDTH-1:0] PIX_LAST = CNT_WIDTH'(DEPTH - 1);
   localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(LOADED_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SYNC,
      COMPUTE,
      CLEAR
   } state_t;

   state_t state, next_state;

   logic [CNT_WIDTH-1:0] pix_cnt;
   logic [TMO_WIDTH-1:0] tmo_cnt;
   logic                 first_cyc;

   logic accept;
   logic pix_clr;
   logic tmo_inc;
   logic tmo_clr;
   logic frame_inc;
   logic set_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // In SYNC abort outranks buf_loaded; in COMPUTE comp_done outranks abort so a finished frame is still counted.
   always_comb begin
      next_state = state;
      s_ready    = 1'b0;
      buf_clear  = 1'b0;
      comp_start = 1'b0;
      accept     = 1'b0;
      pix_clr    = 1'b0;
      tmo_inc    = 1'b0;
      tmo_clr    = 1'b0;
      frame_inc  = 1'b0;
      set_err    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = LOAD;
               pix_clr    = 1'b1;
            end
         end
         LOAD: begin
            if (abort) begin
               next_state = CLEAR;
            end else begin
               s_ready = buf_ready && (pix_cnt < PIX_FULL);
               accept  = s_valid && s_ready;
               if (accept && (pix_cnt == PIX_LAST)) begin
                  next_state = SYNC;
                  tmo_clr    = 1'b1;
               end
            end
         end
         SYNC: begin
            if (abort) begin
               next_state = CLEAR;
            end else if (buf_loaded) begin
               next_state = COMPUTE;
            end else if (tmo_cnt == TMO_LAST) begin
               next_state = CLEAR;
               set_err    = 1'b1;
            end else begin
               tmo_inc = 1'b1;
            end
         end
         COMPUTE: begin
            comp_start = first_cyc;
            if (comp_done) begin
               next_state = CLEAR;
               frame_inc  = 1'b1;
            end else if (abort) begin
               next_state = CLEAR;
            end
         end
         CLEAR: begin
            buf_clear  = 1'b1;
            pix_clr    = 1'b1;
            next_state = auto_rearm ? LOAD : IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   assign buf_load_en = accept;
   assign buf_data    = s_data;
   assign busy        = (state != IDLE);

   // first_cyc remembers that the previous cycle was not COMPUTE, marking the comp_start cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_cnt     <= '0;
         tmo_cnt     <= '0;
         first_cyc   <= 1'b1;
         frame_cnt   <= '0;
         err_timeout <= 1'b0;
      end else begin
         first_cyc <= (state != COMPUTE);
         if (pix_clr) begin
            pix_cnt <= '0;
         end else if (accept) begin
            pix_cnt <= pix_cnt + 1'b1;
         end
         if (tmo_clr) begin
            tmo_cnt <= '0;
         end else if (tmo_inc) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
         if (frame_inc) begin
            frame_cnt <= frame_cnt + 1'b1;
         end
         if (set_err) begin
            err_timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_buffer_load_ctrl.sv
// Self-checking bench for buffer_load_ctrl: expected pixels go into a queue when driven
// and are popped and compared whenever the controller strobes buf_load_en.
module tb_buffer_load_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        auto_rearm = 1'b0;
   logic        abort = 1'b0;
   logic        s_valid = 1'b0;
   logic [7:0]  s_data = 8'h00;
   logic        buf_ready = 1'b1;
   logic        buf_loaded = 1'b0;
   logic        comp_done = 1'b0;
   logic        s_ready;
   logic        buf_load_en;
   logic [7:0]  buf_data;
   logic        buf_clear;
   logic        comp_start;
   logic        busy;
   logic [15:0] frame_cnt;
   logic        err_timeout;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;
   int         load_cnt = 0;
   int         cstart_cnt = 0;
   int         clear_cnt = 0;
   int         busy_low_cnt = 0;
   bit         watch_busy = 1'b0;
   int         exp_frames = 0;

   buffer_load_ctrl #(
      .DATA_WIDTH(8),
      .DEPTH(4),
      .LOADED_TIMEOUT(4),
      .FRAME_CNT_WIDTH(16)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .auto_rearm(auto_rearm),
      .abort(abort),
      .s_valid(s_valid),
      .s_data(s_data),
      .s_ready(s_ready),
      .buf_load_en(buf_load_en),
      .buf_data(buf_data),
      .buf_clear(buf_clear),
      .buf_ready(buf_ready),
      .buf_loaded(buf_loaded),
      .comp_start(comp_start),
      .comp_done(comp_done),
      .busy(busy),
      .frame_cnt(frame_cnt),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   // Monitor samples on the falling edge, mid-cycle, while inputs and outputs are stable.
   always @(negedge clk) begin
      if (rst_n) begin
         if (buf_load_en) begin
            load_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("[TB] FAIL load_unexpected: got load of %02h, expected no load", buf_data);
            end else begin
               mon_exp = exp_q.pop_front();
               if (buf_data !== mon_exp) begin
                  n_err++;
                  $display("[TB] FAIL load_data: got %02h, expected %02h", buf_data, mon_exp);
               end
            end
         end
         if (comp_start) cstart_cnt++;
         if (buf_clear) clear_cnt++;
         if (watch_busy && !busy) busy_low_cnt++;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic push_pixel(input logic [7:0] d);
      s_valid = 1'b1;
      s_data  = d;
      exp_q.push_back(d);
      step;
   endtask

   // Entered in LOAD; leaves the DUT in CLEAR with s_valid still high.
   task automatic good_frame(input logic [7:0] base);
      for (int i = 0; i < 4; i++) push_pixel(8'(base + 8'(i)));
      s_data     = 8'hEE;
      buf_loaded = 1'b1;
      step;
      buf_loaded = 1'b0;
      step;
      comp_done = 1'b1;
      step;
      comp_done = 1'b0;
      exp_frames++;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
      n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("[TB] FAIL reset_s_ready: got %b, expected 0", s_ready); end
      n_cmp++; if (frame_cnt !== 16'd0) begin n_err++; $display("[TB] FAIL reset_frame_cnt: got %0d, expected 0", frame_cnt); end
      n_cmp++; if (err_timeout !== 1'b0) begin n_err++; $display("[TB] FAIL reset_err: got %b, expected 0", err_timeout); end
      n_cmp++; if ({buf_clear, comp_start, buf_load_en} !== 3'b000) begin n_err++; $display("[TB] FAIL reset_strobes: got %b, expected 000", {buf_clear, comp_start, buf_load_en}); end
      rst_n = 1'b1;
      step;
      start = 1'b1;
      step;
      start = 1'b0;
      push_pixel(8'hA1);
      push_pixel(8'hA2);
      s_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL midreset_busy: got %b, expected 0", busy); end
      n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("[TB] FAIL midreset_s_ready: got %b, expected 0", s_ready); end
      n_cmp++; if (frame_cnt !== 16'd0) begin n_err++; $display("[TB] FAIL midreset_frame_cnt: got %0d, expected 0", frame_cnt); end
      step;
      rst_n = 1'b1;
      step;
      start = 1'b1;
      step;
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1;
         s_data  = 8'(8'hB0 + 8'(i));
         #1;
         n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("[TB] FAIL rearm_s_ready_%0d: got %b, expected 1", i, s_ready); end
         exp_q.push_back(s_data);
         step;
      end
      s_valid = 1'b0;
      #1;
      n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("[TB] FAIL rearm_full_s_ready: got %b, expected 0", s_ready); end
      abort = 1'b1;
      step;
      abort = 1'b0;
      n_cmp++; if (buf_clear !== 1'b1) begin n_err++; $display("[TB] FAIL rearm_abort_clear: got %b, expected 1", buf_clear); end
      step;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL rearm_idle_busy: got %b, expected 0", busy); end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("[TB] FAIL reset_queue: got %0d pending, expected 0", exp_q.size()); end
   endtask

   task automatic test_nominal;
      int l0, c0, k0;
      l0 = load_cnt; c0 = cstart_cnt; k0 = clear_cnt;
      auto_rearm = 1'b0;
      start = 1'b1;
      step;
      start = 1'b0;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL nominal_busy: got %b, expected 1", busy); end
      for (int i = 0; i < 4; i++) push_pixel(8'((i + 1) * 8'h11));
      s_valid = 1'b0;
      #1;
      n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("[TB] FAIL nominal_sync_s_ready: got %b, expected 0", s_ready); end
      buf_loaded = 1'b1;
      step;
      buf_loaded = 1'b0;
      n_cmp++; if (comp_start !== 1'b1) begin n_err++; $display("[TB] FAIL nominal_comp_start: got %b, expected 1", comp_start); end
      step;
      n_cmp++; if (comp_start !== 1'b0) begin n_err++; $display("[TB] FAIL nominal_comp_start_pulse: got %b, expected 0", comp_start); end
      step;
      step;
      comp_done = 1'b1;
      step;
      comp_done = 1'b0;
      exp_frames++;
      n_cmp++; if (buf_clear !== 1'b1) begin n_err++; $display("[TB] FAIL nominal_clear: got %b, expected 1", buf_clear); end
      n_cmp++; if (frame_cnt !== 16'(exp_frames)) begin n_err++; $display("[TB] FAIL nominal_frame_cnt: got %0d, expected %0d", frame_cnt, exp_frames); end
      step;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL nominal_idle: got %b, expected 0", busy); end
      n_cmp++; if (load_cnt - l0 != 4) begin n_err++; $display("[TB] FAIL nominal_loads: got %0d, expected 4", load_cnt - l0); end
      n_cmp++; if (cstart_cnt - c0 != 1) begin n_err++; $display("[TB] FAIL nominal_starts: got %0d, expected 1", cstart_cnt - c0); end
      n_cmp++; if (clear_cnt - k0 != 1) begin n_err++; $display("[TB] FAIL nominal_clears: got %0d, expected 1", clear_cnt - k0); end
   endtask

   task automatic test_backpressure;
      int l0, acc, k;
      logic exp_load;
      l0 = load_cnt; acc = 0; k = 0;
      start = 1'b1;
      step;
      start = 1'b0;
      while (acc < 4 && k < 30) begin
         s_valid   = (k % 2 == 0);
         buf_ready = !(k == 2 || k == 3);
         s_data    = 8'(8'h50 + 8'(acc));
         #1;
         exp_load = s_valid && buf_ready;
         n_cmp++; if (buf_load_en !== exp_load) begin n_err++; $display("[TB] FAIL bp_load_en_k%0d: got %b, expected %b", k, buf_load_en, exp_load); end
         if (exp_load) begin
            exp_q.push_back(s_data);
            acc++;
         end
         step;
         k++;
      end
      buf_ready = 1'b1;
      s_valid   = 1'b1;
      s_data    = 8'hFF;
      #1;
      n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("[TB] FAIL bp_full_s_ready: got %b, expected 0", s_ready); end
      buf_loaded = 1'b1;
      step;
      buf_loaded = 1'b0;
      s_valid    = 1'b0;
      comp_done  = 1'b1;
      n_cmp++; if (comp_start !== 1'b1) begin n_err++; $display("[TB] FAIL bp_comp_start: got %b, expected 1", comp_start); end
      step;
      comp_done = 1'b0;
      exp_frames++;
      n_cmp++; if (frame_cnt !== 16'(exp_frames)) begin n_err++; $display("[TB] FAIL bp_frame_cnt: got %0d, expected %0d", frame_cnt, exp_frames); end
      step;
      n_cmp++; if (load_cnt - l0 != 4) begin n_err++; $display("[TB] FAIL bp_loads: got %0d, expected 4", load_cnt - l0); end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("[TB] FAIL bp_queue: got %0d pending, expected 0", exp_q.size()); end
   endtask

   task automatic test_timeout;
      start = 1'b1;
      step;
      start = 1'b0;
      for (int i = 0; i < 4; i++) push_pixel(8'(8'hC0 + 8'(i)));
      s_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step;
         n_cmp++; if ({buf_clear, err_timeout} !== 2'b00) begin n_err++; $display("[TB] FAIL tmo_early_%0d: got clear/err %b, expected 00", i, {buf_clear, err_timeout}); end
      end
      step;
      n_cmp++; if (buf_clear !== 1'b1) begin n_err++; $display("[TB] FAIL tmo_clear: got %b, expected 1", buf_clear); end
      n_cmp++; if (err_timeout !== 1'b1) begin n_err++; $display("[TB] FAIL tmo_err: got %b, expected 1", err_timeout); end
      n_cmp++; if (frame_cnt !== 16'(exp_frames)) begin n_err++; $display("[TB] FAIL tmo_frame_cnt: got %0d, expected %0d", frame_cnt, exp_frames); end
      step;
      start = 1'b1;
      step;
      start = 1'b0;
      good_frame(8'h60);
      s_valid = 1'b0;
      n_cmp++; if (frame_cnt !== 16'(exp_frames)) begin n_err++; $display("[TB] FAIL tmo_good_frame_cnt: got %0d, expected %0d", frame_cnt, exp_frames); end
      step;
      n_cmp++; if (err_timeout !== 1'b1) begin n_err++; $display("[TB] FAIL tmo_err_sticky: got %b, expected 1", err_timeout); end
   endtask

   task automatic test_abort;
      int c0;
      start = 1'b1;
      step;
      start = 1'b0;
      for (int i = 0; i < 4; i++) push_pixel(8'(8'hD0 + 8'(i)));
      s_valid    = 1'b0;
      buf_loaded = 1'b1;
      step;
      buf_loaded = 1'b0;
      step;
      comp_done = 1'b1;
      abort     = 1'b1;
      step;
      comp_done = 1'b0;
      abort     = 1'b0;
      exp_frames++;
      n_cmp++; if (frame_cnt !== 16'(exp_frames)) begin n_err++; $display("[TB] FAIL abort_done_frame_cnt: got %0d, expected %0d", frame_cnt, exp_frames); end
      n_cmp++; if (buf_clear !== 1'b1) begin n_err++; $display("[TB] FAIL abort_done_clear: got %b, expected 1", buf_clear); end
      step;
      c0 = cstart_cnt;
      start = 1'b1;
      step;
      start = 1'b0;
      push_pixel(8'h71);
      push_pixel(8'h72);
      s_data = 8'h77;
      abort  = 1'b1;
      #1;
      n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("[TB] FAIL abort_load_s_ready: got %b, expected 0", s_ready); end
      n_cmp++; if (buf_load_en !== 1'b0) begin n_err++; $display("[TB] FAIL abort_load_en: got %b, expected 0", buf_load_en); end
      step;
      abort   = 1'b0;
      s_valid = 1'b0;
      n_cmp++; if (buf_clear !== 1'b1) begin n_err++; $display("[TB] FAIL abort_load_clear: got %b, expected 1", buf_clear); end
      step;
      n_cmp++; if (frame_cnt !== 16'(exp_frames)) begin n_err++; $display("[TB] FAIL abort_load_frame_cnt: got %0d, expected %0d", frame_cnt, exp_frames); end
      n_cmp++; if (cstart_cnt != c0) begin n_err++; $display("[TB] FAIL abort_load_comp_start: got %0d pulses, expected 0", cstart_cnt - c0); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL abort_load_idle: got %b, expected 0", busy); end
   endtask

   task automatic test_auto_rearm;
      int k0;
      rst_n = 1'b0;
      step;
      rst_n = 1'b1;
      exp_frames = 0;
      step;
      k0 = clear_cnt;
      auto_rearm = 1'b1;
      start = 1'b1;
      step;
      start = 1'b0;
      watch_busy = 1'b1;
      for (int f = 0; f < 3; f++) begin
         good_frame(8'(8'h80 + 8'(f * 16)));
         n_cmp++; if (buf_clear !== 1'b1) begin n_err++; $display("[TB] FAIL rearm_clear_%0d: got %b, expected 1", f, buf_clear); end
         if (f == 2) begin
            auto_rearm = 1'b0;
            watch_busy = 1'b0;
            s_valid    = 1'b0;
         end
         step;
         if (f < 2) begin
            n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("[TB] FAIL rearm_load_%0d: got s_ready %b, expected 1", f, s_ready); end
         end
      end
      n_cmp++; if (frame_cnt !== 16'd3) begin n_err++; $display("[TB] FAIL rearm_frame_cnt: got %0d, expected 3", frame_cnt); end
      n_cmp++; if (busy_low_cnt != 0) begin n_err++; $display("[TB] FAIL rearm_busy_drop: got %0d idle cycles, expected 0", busy_low_cnt); end
      n_cmp++; if (clear_cnt - k0 != 3) begin n_err++; $display("[TB] FAIL rearm_clears: got %0d, expected 3", clear_cnt - k0); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL rearm_final_idle: got %b, expected 0", busy); end
   endtask

   initial begin
      $display("[TB] starting buffer_load_ctrl bench");
      test_reset;
      test_nominal;
      test_backpressure;
      test_timeout;
      test_abort;
      test_auto_rearm;
      repeat (2) step;
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("[TB] FAIL final_queue: got %0d pending, expected 0", exp_q.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
